// File: rtl/muxdff_chain.sv
// Bank of DEPTH mux-fronted WIDTH-bit flip-flops with hold/load/shift/rotate/clear next-state
// selection and a command handshake that runs multi-step shift/rotate bursts.
module muxdff_chain #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LEN_W = 4
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_mode,
  input  logic [LEN_W-1:0]       cmd_len,
  input  logic [DEPTH*WIDTH-1:0] par_in,
  input  logic [WIDTH-1:0]       ser_in,
  output logic [DEPTH*WIDTH-1:0] q,
  output logic [WIDTH-1:0]       ser_out,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned DW = DEPTH * WIDTH;

  typedef enum logic [2:0] {
    ModeHold  = 3'd0,
    ModeLoad  = 3'd1,
    ModeShUp  = 3'd2,
    ModeShDn  = 3'd3,
    ModeRotUp = 3'd4,
    ModeRotDn = 3'd5,
    ModeClear = 3'd6,
    ModeRsvd  = 3'd7
  } mode_e;

  typedef enum logic {StIdle, StRun} state_e;

  state_e           state_q;
  mode_e            mode_q;
  logic [LEN_W-1:0] rem_q;
  logic             dir_dn_q;
  logic             done_q;
  logic [DW-1:0]    stages_q;
  logic [DW-1:0]    stages_d;
  logic             accept;
  logic             apply;
  logic             is_burst;
  mode_e            step_mode;

  assign accept   = cmd_valid && (state_q == StIdle);
  assign apply    = accept || (state_q == StRun);
  assign is_burst = cmd_mode inside {3'd2, 3'd3, 3'd4, 3'd5};

  // In RUN the latched mode drives the mux; cmd_mode only matters on the accepting edge.
  assign step_mode = (state_q == StRun) ? mode_q : mode_e'(cmd_mode);

  // Stage 0 sits in the least significant slice, so "up" moves data toward the MSBs.
  always_comb begin
    stages_d = stages_q;
    if (apply) begin
      unique case (step_mode)
        ModeLoad:  stages_d = par_in;
        ModeClear: stages_d = '0;
        ModeShUp:  stages_d = {stages_q[DW-WIDTH-1:0], ser_in};
        ModeShDn:  stages_d = {ser_in, stages_q[DW-1:WIDTH]};
        ModeRotUp: stages_d = {stages_q[DW-WIDTH-1:0], stages_q[DW-1 -: WIDTH]};
        ModeRotDn: stages_d = {stages_q[WIDTH-1:0], stages_q[DW-1:WIDTH]};
        default:   stages_d = stages_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= StIdle;
      mode_q   <= ModeHold;
      rem_q    <= '0;
      dir_dn_q <= 1'b0;
      done_q   <= 1'b0;
      stages_q <= '0;
    end else begin
      stages_q <= stages_d;
      done_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            mode_q <= mode_e'(cmd_mode);
            if (is_burst) begin
              dir_dn_q <= (cmd_mode == ModeShDn) || (cmd_mode == ModeRotDn);
            end
            if (is_burst && (cmd_len != '0)) begin
              rem_q   <= cmd_len;
              state_q <= StRun;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        StRun: begin
          rem_q <= rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign q         = stages_q;
  assign ser_out   = dir_dn_q ? stages_q[WIDTH-1:0] : stages_q[DW-1 -: WIDTH];
  assign busy      = (state_q == StRun);
  assign cmd_ready = (state_q == StIdle);
  assign done      = done_q;

endmodule

// File: tb/tb_muxdff_chain.sv
// Directed bench for muxdff_chain: array-based stage model feeds a scoreboard of expected
// q/ser_out values that are popped and compared one edge later.
module tb_muxdff_chain;

  localparam int unsigned W = 4;
  localparam int unsigned D = 4;
  localparam int unsigned L = 4;

  logic         clk = 1'b0;
  logic         aresetn = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_mode = '0;
  logic [L-1:0] cmd_len = '0;
  logic [D*W-1:0] par_in = '0;
  logic [W-1:0] ser_in = '0;
  logic [D*W-1:0] q;
  logic [W-1:0] ser_out;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;

  logic [W-1:0]   m [D];
  bit             dir_up = 1'b1;
  logic [D*W-1:0] sb_q [$];
  logic [W-1:0]   sb_ser [$];

  muxdff_chain #(.WIDTH(W), .DEPTH(D), .LEN_W(L)) dut (
    .clk       (clk),
    .aresetn   (aresetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_len   (cmd_len),
    .par_in    (par_in),
    .ser_in    (ser_in),
    .q         (q),
    .ser_out   (ser_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [D*W-1:0] pack_m();
    logic [D*W-1:0] r;
    for (int i = 0; i < D; i++) r[i*W +: W] = m[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) m[i] = '0;
    dir_up = 1'b1;
  endtask

  // One step of the stage array as defined by the mode table.
  task automatic model_step(input logic [2:0] mode);
    logic [W-1:0] t;
    case (mode)
      3'd1: for (int i = 0; i < D; i++) m[i] = par_in[i*W +: W];
      3'd2: begin
        for (int i = D - 1; i > 0; i--) m[i] = m[i-1];
        m[0] = ser_in;
        dir_up = 1'b1;
      end
      3'd3: begin
        for (int i = 0; i < D - 1; i++) m[i] = m[i+1];
        m[D-1] = ser_in;
        dir_up = 1'b0;
      end
      3'd4: begin
        t = m[D-1];
        for (int i = D - 1; i > 0; i--) m[i] = m[i-1];
        m[0] = t;
        dir_up = 1'b1;
      end
      3'd5: begin
        t = m[0];
        for (int i = 0; i < D - 1; i++) m[i] = m[i+1];
        m[D-1] = t;
        dir_up = 1'b0;
      end
      3'd6: for (int i = 0; i < D; i++) m[i] = '0;
      default: ;
    endcase
  endtask

  // step_mode is the update this edge should apply (0 = none).
  task automatic cyc(input string tag, input logic [2:0] step_mode, input bit exp_busy,
                     input bit exp_done);
    logic [D*W-1:0] eq;
    logic [W-1:0]   es;
    model_step(step_mode);
    sb_q.push_back(pack_m());
    sb_ser.push_back(dir_up ? m[D-1] : m[0]);
    @(posedge clk);
    #1;
    eq = sb_q.pop_front();
    es = sb_ser.pop_front();
    check({tag, ".q"}, 64'(q), 64'(eq));
    check({tag, ".ser_out"}, 64'(ser_out), 64'(es));
    check({tag, ".busy"}, 64'(busy), 64'(exp_busy));
    check({tag, ".done"}, 64'(done), 64'(exp_done));
    check({tag, ".cmd_ready"}, 64'(cmd_ready), 64'(!exp_busy));
  endtask

  task automatic set_cmd(input bit v, input logic [2:0] md, input logic [L-1:0] ln,
                         input logic [D*W-1:0] p, input logic [W-1:0] s);
    cmd_valid = v;
    cmd_mode  = md;
    cmd_len   = ln;
    par_in    = p;
    ser_in    = s;
  endtask

  initial begin
    model_reset();

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      set_cmd(1'($urandom), 3'($urandom), L'($urandom), (D*W)'($urandom), W'($urandom));
      @(posedge clk);
      #1;
      check("rst.q", 64'(q), 64'h0);
      check("rst.busy", 64'(busy), 64'h0);
      check("rst.done", 64'(done), 64'h0);
      check("rst.ready", 64'(cmd_ready), 64'h1);
      check("rst.ser_out", 64'(ser_out), 64'h0);
    end
    set_cmd(1'b0, 3'd0, '0, '0, '0);
    #2 aresetn = 1'b1;
    @(posedge clk);
    #1;

    // Load then hold, back-to-back single-step commands
    set_cmd(1'b1, 3'd1, '0, 16'h4321, 4'h0);
    cyc("load", 3'd1, 1'b0, 1'b1);
    check("load.const", 64'(q), 64'h4321);
    set_cmd(1'b1, 3'd0, '0, 16'hFFFF, 4'h0);
    cyc("hold", 3'd0, 1'b0, 1'b1);
    check("hold.const", 64'(q), 64'h4321);
    cmd_valid = 1'b0;
    cyc("idle0", 3'd0, 1'b0, 1'b0);

    // Shift-up burst of two steps; cmd_mode scrambled during RUN
    set_cmd(1'b1, 3'd2, 4'd1, '0, 4'hA);
    cyc("shup1", 3'd2, 1'b1, 1'b0);
    check("shup1.const", 64'(q), 64'h321A);
    set_cmd(1'b0, 3'd6, 4'd7, '0, 4'hB);
    cyc("shup2", 3'd2, 1'b0, 1'b1);
    check("shup2.const", 64'(q), 64'h21AB);
    check("shup2.ser", 64'(ser_out), 64'h2);

    // Reload, then single-step rotate down accepted in the done cycle
    set_cmd(1'b1, 3'd1, '0, 16'h4321, 4'h0);
    cyc("reload", 3'd1, 1'b0, 1'b1);
    set_cmd(1'b1, 3'd5, 4'd0, '0, 4'h0);
    cyc("rotdn", 3'd5, 1'b0, 1'b1);
    check("rotdn.const", 64'(q), 64'h1432);
    check("rotdn.ser", 64'(ser_out), 64'h2);
    cmd_valid = 1'b0;
    cyc("idle1", 3'd0, 1'b0, 1'b0);

    // Busy gating: clear offered throughout a 4-step shift-down burst
    set_cmd(1'b1, 3'd3, 4'd3, '0, 4'h5);
    cyc("shdn1", 3'd3, 1'b1, 1'b0);
    set_cmd(1'b1, 3'd6, 4'd0, '0, 4'h6);
    cyc("shdn2", 3'd3, 1'b1, 1'b0);
    ser_in = 4'h7;
    cyc("shdn3", 3'd3, 1'b1, 1'b0);
    ser_in = 4'h8;
    cyc("shdn4", 3'd3, 1'b0, 1'b1);
    check("shdn4.const", 64'(q), 64'h8765);
    cyc("clear", 3'd6, 1'b0, 1'b1);
    check("clear.const", 64'(q), 64'h0);

    // Maximum length rotate-up: 16 rotations restore the pattern
    set_cmd(1'b1, 3'd1, '0, 16'h4321, 4'h0);
    cyc("load2", 3'd1, 1'b0, 1'b1);
    set_cmd(1'b1, 3'd4, 4'd15, '0, 4'h0);
    for (int i = 0; i < 16; i++) begin
      cyc("rotup", 3'd4, i < 15, i == 15);
      cmd_valid = 1'b0;
      ser_in = W'($urandom);
    end
    check("rotup.const", 64'(q), 64'h4321);
    check("rotup.ser", 64'(ser_out), 64'h4);
    cyc("idle2", 3'd0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a long shift-up burst
    set_cmd(1'b1, 3'd2, 4'd15, '0, W'($urandom));
    for (int i = 0; i < 5; i++) begin
      cyc("burst", 3'd2, 1'b1, 1'b0);
      cmd_valid = 1'b0;
      ser_in = W'($urandom);
    end
    #1 aresetn = 1'b0;
    model_reset();
    #1;
    check("arst.q", 64'(q), 64'h0);
    check("arst.busy", 64'(busy), 64'h0);
    check("arst.ready", 64'(cmd_ready), 64'h1);
    check("arst.ser_out", 64'(ser_out), 64'h0);
    check("arst.done", 64'(done), 64'h0);
    #2 aresetn = 1'b1;
    cyc("post_rst", 3'd0, 1'b0, 1'b0);

    // Normal operation resumes
    set_cmd(1'b1, 3'd1, '0, 16'hA5C3, 4'h0);
    cyc("load3", 3'd1, 1'b0, 1'b1);
    set_cmd(1'b1, 3'd3, 4'd1, '0, 4'h9);
    cyc("shdn_a", 3'd3, 1'b1, 1'b0);
    set_cmd(1'b0, 3'd0, '0, '0, 4'hE);
    cyc("shdn_b", 3'd3, 1'b0, 1'b1);
    check("shdn_b.const", 64'(q), 64'hE9A5);
    check("shdn_b.ser", 64'(ser_out), 64'h5);
    cyc("idle3", 3'd0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
